// File: rtl/nand_flash_responder.sv
// nand_flash_responder
//
// NAND flash target model for the far end of the controller's flash bus.
// It decodes command, address and data strobes. It holds a small page
// array behind a one-page register. It answers page read, page program,
// read status, read ID and reset, and holds R/B low for a realistic busy
// window after each array operation.
//
// Ports
//   P_clk    system clock; every bus input is sampled on its rising edge
//   P_rst    synchronous reset, active high
//   F_nCE    chip enable, active low; when high, strobes are ignored and DIO is released
//   F_CLE    command latch enable
//   F_ALE    address latch enable
//   F_nWE    write strobe; the byte is latched on its rising edge
//   F_nRE    read strobe; the target drives DIO while it is low
//   F_nWP    write protect, active low
//   F_nRB    ready/busy (registered), low = busy
//   F_DIO    bidirectional command/address/data bus
//
// Sequencer
//   state  | meaning
//   S_IDLE | no command sequence open; only top-level commands act
//   S_ADDR | collecting address cycles for the opcode in op_q
//   S_CONF | address complete; waiting for data-in or the confirm command
//
// Output mode (selects what DIO returns during nRE low)
//   mode     | meaning
//   M_NONE   | DIO never driven
//   M_PAGE   | page_reg[col], only once busy has ended
//   M_STATUS | status byte
//   M_ID     | ID0/ID1, alternating per read strobe

module nand_flash_responder #(
   parameter int          PAGE_BYTES = 16,
   parameter int          NUM_PAGES  = 8,
   parameter int          T_BUSY     = 20,
   parameter int          T_RST      = 4,
   parameter logic [7:0]  ID0        = 8'hEC,
   parameter logic [7:0]  ID1        = 8'hD3
) (
   input  logic        P_clk,
   input  logic        P_rst,
   input  logic        F_nCE,
   input  logic        F_CLE,
   input  logic        F_ALE,
   input  logic        F_nWE,
   input  logic        F_nRE,
   input  logic        F_nWP,
   output logic        F_nRB,
   inout  wire  [7:0]  F_DIO
);

   localparam int COL_W = $clog2(PAGE_BYTES);
   localparam int PG_W  = $clog2(NUM_PAGES);
   localparam int T_MAX = (T_BUSY > T_RST) ? T_BUSY : T_RST;
   localparam int CNT_W = $clog2(T_MAX + 1);

   localparam logic [7:0] CMD_READ      = 8'h00;
   localparam logic [7:0] CMD_READ_CONF = 8'h30;
   localparam logic [7:0] CMD_PROG      = 8'h80;
   localparam logic [7:0] CMD_PROG_CONF = 8'h10;
   localparam logic [7:0] CMD_STATUS    = 8'h70;
   localparam logic [7:0] CMD_ID        = 8'h90;
   localparam logic [7:0] CMD_RESET     = 8'hFF;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_CONF} seq_t;
   typedef enum logic [1:0] {M_NONE, M_PAGE, M_STATUS, M_ID} mode_t;
   typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ID} op_t;

   seq_t              state_q, state_d;
   mode_t             mode_q,  mode_d;
   op_t               op_q,    op_d;
   logic [2:0]        addr_cnt_q, addr_cnt_d;
   logic [COL_W-1:0]  col_q,   col_d;
   logic [PG_W-1:0]   page_q,  page_d;
   logic              id_idx_q, id_idx_d;
   logic              fail_q,  fail_d;
   logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

   logic              nwe_q, nre_q, cle_q, ale_q;
   logic [7:0]        dio_q;

   logic              wr_strobe, rd_strobe, busy;
   logic              din_we, load_page, commit_page;
   logic              oe;
   logic [7:0]        dout, status_byte;

   logic [7:0]        page_reg [PAGE_BYTES];
   logic [7:0]        mem      [NUM_PAGES][PAGE_BYTES];

   // Strobes are the registered low phase followed by a high pin, so a
   // strobe acts one cycle after its rising edge reaches the pins.
   assign wr_strobe = !nwe_q && F_nWE && !F_nCE;
   assign rd_strobe = !nre_q && F_nRE && !F_nCE;
   assign busy      = (busy_cnt_q != '0);

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      op_d        = op_q;
      addr_cnt_d  = addr_cnt_q;
      col_d       = col_q;
      page_d      = page_q;
      id_idx_d    = id_idx_q;
      fail_d      = fail_q;
      busy_cnt_d  = busy ? busy_cnt_q - CNT_W'(1) : busy_cnt_q;
      din_we      = 1'b0;
      load_page   = 1'b0;
      commit_page = 1'b0;

      if (wr_strobe) begin
         case ({cle_q, ale_q})
            2'b10: begin
               // Reset and status are honoured even while busy; a reset
               // restarts the busy window with the shorter reset time.
               if (dio_q == CMD_RESET) begin
                  state_d    = S_IDLE;
                  mode_d     = M_NONE;
                  col_d      = '0;
                  fail_d     = 1'b0;
                  busy_cnt_d = CNT_W'(T_RST);
               end else if (dio_q == CMD_STATUS) begin
                  mode_d = M_STATUS;
               end else if (!busy) begin
                  case (dio_q)
                     CMD_READ, CMD_PROG: begin
                        state_d    = S_ADDR;
                        op_d       = (dio_q == CMD_READ) ? OP_READ : OP_PROG;
                        addr_cnt_d = 3'd0;
                        mode_d     = M_NONE;
                     end
                     CMD_ID: begin
                        state_d    = S_ADDR;
                        op_d       = OP_ID;
                        addr_cnt_d = 3'd0;
                     end
                     CMD_READ_CONF: begin
                        if (state_q == S_CONF && op_q == OP_READ) begin
                           load_page  = 1'b1;
                           busy_cnt_d = CNT_W'(T_BUSY);
                           mode_d     = M_PAGE;
                           state_d    = S_IDLE;
                        end
                     end
                     CMD_PROG_CONF: begin
                        if (state_q == S_CONF && op_q == OP_PROG) begin
                           commit_page = F_nWP;
                           fail_d      = !F_nWP;
                           busy_cnt_d  = CNT_W'(T_BUSY);
                           mode_d      = M_NONE;
                           state_d     = S_IDLE;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            2'b01: begin
               if (state_q == S_ADDR) begin
                  if (op_q == OP_ID) begin
                     state_d  = S_IDLE;
                     mode_d   = M_ID;
                     id_idx_d = 1'b0;
                  end else begin
                     // Byte 0 = column, byte 2 = page; bytes 1, 3, 4 are
                     // row/column high bytes this small array ignores.
                     if (addr_cnt_q == 3'd0) col_d  = dio_q[COL_W-1:0];
                     if (addr_cnt_q == 3'd2) page_d = dio_q[PG_W-1:0];
                     if (addr_cnt_q == 3'd4) state_d = S_CONF;
                     addr_cnt_d = addr_cnt_q + 3'd1;
                  end
               end
            end
            2'b00: begin
               if (state_q == S_CONF && op_q == OP_PROG) begin
                  din_we = 1'b1;
                  col_d  = col_q + COL_W'(1);
               end
            end
            default: ;
         endcase
      end

      if (rd_strobe) begin
         if (mode_q == M_PAGE)
            col_d = col_q + COL_W'(1);
         else if (mode_q == M_ID)
            id_idx_d = !id_idx_q;
      end
   end

   always_ff @(posedge P_clk) begin
      if (P_rst) begin
         state_q    <= S_IDLE;
         mode_q     <= M_NONE;
         op_q       <= OP_READ;
         addr_cnt_q <= 3'd0;
         col_q      <= '0;
         page_q     <= '0;
         id_idx_q   <= 1'b0;
         fail_q     <= 1'b0;
         busy_cnt_q <= '0;
         nwe_q      <= 1'b1;
         nre_q      <= 1'b1;
         cle_q      <= 1'b0;
         ale_q      <= 1'b0;
         dio_q      <= 8'h00;
         F_nRB      <= 1'b1;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         op_q       <= op_d;
         addr_cnt_q <= addr_cnt_d;
         col_q      <= col_d;
         page_q     <= page_d;
         id_idx_q   <= id_idx_d;
         fail_q     <= fail_d;
         busy_cnt_q <= busy_cnt_d;
         nwe_q      <= F_nWE;
         nre_q      <= F_nRE;
         cle_q      <= F_CLE;
         ale_q      <= F_ALE;
         dio_q      <= F_DIO;
         // Registered from the current count so R/B falls on the edge after
         // the count is loaded and stays low for exactly the loaded value.
         F_nRB      <= (busy_cnt_q == '0);
      end
   end

   // Array storage is deliberately not reset.
   always_ff @(posedge P_clk) begin
      if (!P_rst) begin
         if (load_page)
            page_reg <= mem[page_q];
         else if (din_we)
            page_reg[col_q] <= dio_q;
         if (commit_page)
            mem[page_q] <= page_reg;
      end
   end

   assign status_byte = {F_nWP, !busy, !busy, 4'b0000, fail_q};

   always_comb begin
      case (mode_q)
         M_PAGE:   dout = page_reg[col_q];
         M_STATUS: dout = status_byte;
         M_ID:     dout = id_idx_q ? ID1 : ID0;
         default:  dout = 8'h00;
      endcase
   end

   assign oe = !F_nCE && !F_nRE && !F_CLE && !F_ALE && (mode_q != M_NONE) &&
               ((mode_q != M_PAGE) || !busy);

   assign F_DIO = oe ? dout : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_nand_flash_responder.sv
module tb_nand_flash_responder;

   localparam int PB     = 16;
   localparam int NP     = 8;
   localparam int T_BUSY = 20;
   localparam int T_RST  = 4;

   logic       P_clk = 1'b0;
   logic       P_rst;
   logic       F_nCE, F_CLE, F_ALE, F_nWE, F_nRE, F_nWP;
   logic       F_nRB;
   wire  [7:0] F_DIO;
   logic       dio_en;
   logic [7:0] dio_drv;

   assign F_DIO = dio_en ? dio_drv : 8'bzzzz_zzzz;

   always #5 P_clk = ~P_clk;

   nand_flash_responder #(
      .PAGE_BYTES(PB), .NUM_PAGES(NP), .T_BUSY(T_BUSY), .T_RST(T_RST),
      .ID0(8'hEC), .ID1(8'hD3)
   ) dut (
      .P_clk(P_clk), .P_rst(P_rst), .F_nCE(F_nCE), .F_CLE(F_CLE),
      .F_ALE(F_ALE), .F_nWE(F_nWE), .F_nRE(F_nRE), .F_nWP(F_nWP),
      .F_nRB(F_nRB), .F_DIO(F_DIO)
   );

   // Reference model: array contents, page buffer, program-fail flag.
   logic [7:0] m_mem  [NP][PB];
   logic [7:0] m_preg [PB];
   logic       m_fail;
   logic [7:0] wbuf   [PB];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [7:0] exp_status(input logic wp_n, input logic rdy);
      return {wp_n, rdy, rdy, 4'b0000, m_fail};
   endfunction

   task automatic bus_write(input logic cle, input logic ale, input logic [7:0] d);
      @(negedge P_clk);
      F_CLE = cle; F_ALE = ale; dio_drv = d; dio_en = 1'b1; F_nWE = 1'b0;
      @(negedge P_clk);
      F_nWE = 1'b1;
      @(negedge P_clk);
      dio_en = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
   endtask

   task automatic cmd(input logic [7:0] d); bus_write(1'b1, 1'b0, d); endtask
   task automatic adr(input logic [7:0] d); bus_write(1'b0, 1'b1, d); endtask
   task automatic din(input logic [7:0] d); bus_write(1'b0, 1'b0, d); endtask

   task automatic bus_read(output logic [7:0] d);
      @(negedge P_clk);
      F_nRE = 1'b0;
      #1 d = F_DIO;
      @(negedge P_clk);
      F_nRE = 1'b1;
      @(negedge P_clk);
   endtask

   // Bench drives 00 weakly-equivalent: any DUT drive alongside shows up
   // as a non-00 (or unknown) value on the shared net.
   task automatic probe(output logic [7:0] d);
      dio_drv = 8'h00; dio_en = 1'b1;
      #1 d = F_DIO;
      dio_en = 1'b0;
   endtask

   task automatic count_busy(input int limit, output int low);
      low = 0;
      for (int i = 0; i < limit; i++) begin
         @(negedge P_clk);
         if (F_nRB === 1'b0) low++;
         else if (low > 0) break;
      end
   endtask

   task automatic send_addr(input logic [7:0] cb, input logic [7:0] pb);
      adr(cb); adr(8'($urandom)); adr(pb); adr(8'($urandom)); adr(8'($urandom));
   endtask

   task automatic do_program(input logic [7:0] pb, input logic [7:0] cb, input int n,
                             input logic wp_n, output int low);
      F_nWP = wp_n;
      cmd(8'h80);
      send_addr(cb, pb);
      for (int i = 0; i < n; i++) begin
         din(wbuf[i]);
         m_preg[(int'(cb) + i) % PB] = wbuf[i];
      end
      cmd(8'h10);
      if (wp_n)
         for (int i = 0; i < PB; i++) m_mem[int'(pb) % NP][i] = m_preg[i];
      m_fail = !wp_n;
      count_busy(80, low);
   endtask

   task automatic load_page(input logic [7:0] pb, input logic [7:0] cb, output int low);
      cmd(8'h00);
      send_addr(cb, pb);
      cmd(8'h30);
      for (int i = 0; i < PB; i++) m_preg[i] = m_mem[int'(pb) % NP][i];
      count_busy(80, low);
   endtask

   task automatic test_reset;
      logic [7:0] d;
      P_rst = 1'b1;
      repeat (3) @(negedge P_clk);
      P_rst = 1'b0;
      @(negedge P_clk);
      n_checks++;
      if (F_nRB !== 1'b1) begin
         n_fail++; $display("FAIL reset_rb: got %b expected 1", F_nRB);
      end
      F_nRE = 1'b0;
      probe(d);
      F_nRE = 1'b1;
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++; $display("FAIL reset_dio_released: got %h expected 00", d);
      end
      m_fail = 1'b0;
      cmd(8'h70);
      bus_read(d);
      n_checks++;
      if (d !== exp_status(1'b1, 1'b1)) begin
         n_fail++; $display("FAIL reset_status: got %h expected %h", d, exp_status(1'b1, 1'b1));
      end
   endtask

   task automatic test_fill;
      int low;
      for (int p = 0; p < NP; p++) begin
         for (int i = 0; i < PB; i++) wbuf[i] = 8'($urandom);
         do_program(8'(p), 8'h00, PB, 1'b1, low);
         n_checks++;
         if (low != T_BUSY) begin
            n_fail++; $display("FAIL fill_busy page %0d: got %0d cycles expected %0d", p, low, T_BUSY);
         end
      end
   endtask

   task automatic test_program_read;
      int low;
      logic [7:0] d;
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
      do_program(8'h02, 8'h03, 3, 1'b1, low);
      n_checks++;
      if (low != T_BUSY) begin
         n_fail++; $display("FAIL prog_busy: got %0d cycles expected %0d", low, T_BUSY);
      end
      load_page(8'h02, 8'h03, low);
      n_checks++;
      if (low != T_BUSY) begin
         n_fail++; $display("FAIL read_busy: got %0d cycles expected %0d", low, T_BUSY);
      end
      for (int i = 0; i < 3; i++) begin
         bus_read(d);
         n_checks++;
         if (d !== m_preg[3 + i]) begin
            n_fail++; $display("FAIL prog_read byte %0d: got %h expected %h", i, d, m_preg[3 + i]);
         end
      end
   endtask

   task automatic test_col_wrap;
      int low;
      logic [7:0] d, pb;
      pb = 8'($urandom);
      for (int i = 0; i < PB; i++) wbuf[i] = 8'($urandom);
      do_program(pb, 8'h0E, PB, 1'b1, low);
      load_page(pb, 8'h00, low);
      for (int i = 0; i < PB; i++) begin
         bus_read(d);
         n_checks++;
         if (d !== m_preg[i]) begin
            n_fail++; $display("FAIL col_wrap col %0d: got %h expected %h", i, d, m_preg[i]);
         end
      end
   endtask

   task automatic test_status_busy;
      int low;
      logic [7:0] d;
      cmd(8'h00);
      send_addr(8'($urandom), 8'($urandom));
      cmd(8'h30);
      cmd(8'h70);
      bus_read(d);
      n_checks++;
      if (d !== exp_status(1'b1, 1'b0)) begin
         n_fail++; $display("FAIL status_busy: got %h expected %h", d, exp_status(1'b1, 1'b0));
      end
      count_busy(80, low);
      bus_read(d);
      n_checks++;
      if (d !== exp_status(1'b1, 1'b1)) begin
         n_fail++; $display("FAIL status_after_busy: got %h expected %h", d, exp_status(1'b1, 1'b1));
      end
   endtask

   task automatic test_write_protect;
      int low;
      logic [7:0] d;
      for (int i = 0; i < PB; i++) wbuf[i] = 8'($urandom);
      do_program(8'h05, 8'h00, PB, 1'b0, low);
      n_checks++;
      if (low != T_BUSY) begin
         n_fail++; $display("FAIL wp_busy: got %0d cycles expected %0d", low, T_BUSY);
      end
      cmd(8'h70);
      bus_read(d);
      n_checks++;
      if (d !== 8'h61) begin
         n_fail++; $display("FAIL wp_status: got %h expected 61", d);
      end
      F_nWP = 1'b1;
      load_page(8'h05, 8'h00, low);
      for (int i = 0; i < PB; i++) begin
         bus_read(d);
         n_checks++;
         if (d !== m_preg[i]) begin
            n_fail++; $display("FAIL wp_unchanged col %0d: got %h expected %h", i, d, m_preg[i]);
         end
      end
   endtask

   task automatic test_read_id;
      logic [7:0] d, e;
      cmd(8'h90);
      adr(8'h00);
      for (int i = 0; i < 4; i++) begin
         e = (i % 2 == 0) ? 8'hEC : 8'hD3;
         bus_read(d);
         n_checks++;
         if (d !== e) begin
            n_fail++; $display("FAIL read_id %0d: got %h expected %h", i, d, e);
         end
      end
      @(negedge P_clk);
      F_nCE = 1'b1;
      F_nRE = 1'b0;
      probe(d);
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++; $display("FAIL id_nce_released: got %h expected 00", d);
      end
      @(negedge P_clk);
      F_nRE = 1'b1;
      @(negedge P_clk);
      F_nCE = 1'b0;
      bus_read(d);
      n_checks++;
      if (d !== 8'hEC) begin
         n_fail++; $display("FAIL id_nce_no_advance: got %h expected EC", d);
      end
   endtask

   task automatic test_reset_cmd;
      int low;
      logic [7:0] d;
      cmd(8'h00);
      adr(8'($urandom));
      adr(8'($urandom));
      cmd(8'hFF);
      m_fail = 1'b0;
      count_busy(40, low);
      n_checks++;
      if (low != T_RST) begin
         n_fail++; $display("FAIL ff_mid_addr_busy: got %0d cycles expected %0d", low, T_RST);
      end
      cmd(8'h30);
      count_busy(40, low);
      n_checks++;
      if (low != 0) begin
         n_fail++; $display("FAIL ff_idle_ignores_30: got %0d busy cycles expected 0", low);
      end
      F_nWP = 1'b1;
      cmd(8'h80);
      send_addr(8'h00, 8'h06);
      for (int i = 0; i < PB; i++) begin
         wbuf[i] = 8'($urandom);
         din(wbuf[i]);
         m_preg[i] = wbuf[i];
      end
      cmd(8'h10);
      for (int i = 0; i < PB; i++) m_mem[6][i] = m_preg[i];
      cmd(8'hFF);
      m_fail = 1'b0;
      count_busy(40, low);
      n_checks++;
      if (low != T_RST) begin
         n_fail++; $display("FAIL ff_mid_busy: got %0d cycles expected %0d", low, T_RST);
      end
      cmd(8'h70);
      bus_read(d);
      n_checks++;
      if (d !== exp_status(1'b1, 1'b1)) begin
         n_fail++; $display("FAIL ff_status: got %h expected %h", d, exp_status(1'b1, 1'b1));
      end
   endtask

   task automatic test_prst_busy;
      int low;
      logic [7:0] d;
      cmd(8'h00);
      send_addr(8'($urandom), 8'($urandom));
      cmd(8'h30);
      repeat (2) @(negedge P_clk);
      F_nRE = 1'b0;
      probe(d);
      F_nRE = 1'b1;
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++; $display("FAIL page_hidden_while_busy: got %h expected 00", d);
      end
      @(negedge P_clk);
      P_rst = 1'b1;
      @(negedge P_clk);
      P_rst = 1'b0;
      m_fail = 1'b0;
      n_checks++;
      if (F_nRB !== 1'b1) begin
         n_fail++; $display("FAIL prst_rb: got %b expected 1", F_nRB);
      end
      F_nRE = 1'b0;
      probe(d);
      F_nRE = 1'b1;
      n_checks++;
      if (d !== 8'h00) begin
         n_fail++; $display("FAIL prst_dio_released: got %h expected 00", d);
      end
      count_busy(30, low);
      n_checks++;
      if (low != 0) begin
         n_fail++; $display("FAIL prst_stays_ready: got %0d busy cycles expected 0", low);
      end
   endtask

   task automatic test_random;
      int low, n, nr;
      logic [7:0] d, pb, cb;
      logic wp;
      for (int it = 0; it < 8; it++) begin
         pb = 8'($urandom);
         cb = 8'($urandom);
         n  = $urandom_range(1, PB);
         wp = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
         do_program(pb, cb, n, wp, low);
         n_checks++;
         if (low != T_BUSY) begin
            n_fail++; $display("FAIL rnd_prog_busy %0d: got %0d cycles expected %0d", it, low, T_BUSY);
         end
         cmd(8'h70);
         bus_read(d);
         n_checks++;
         if (d !== exp_status(wp, 1'b1)) begin
            n_fail++; $display("FAIL rnd_status %0d: got %h expected %h", it, d, exp_status(wp, 1'b1));
         end
         F_nWP = 1'b1;
         pb = ($urandom_range(0, 1) != 0) ? pb : 8'($urandom);
         cb = 8'($urandom);
         nr = $urandom_range(1, PB + 4);
         load_page(pb, cb, low);
         for (int i = 0; i < nr; i++) begin
            bus_read(d);
            n_checks++;
            if (d !== m_preg[(int'(cb) + i) % PB]) begin
               n_fail++;
               $display("FAIL rnd_read %0d byte %0d: got %h expected %h", it, i, d, m_preg[(int'(cb) + i) % PB]);
            end
         end
      end
   endtask

   initial begin
      P_rst = 1'b1; F_nCE = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
      F_nWE = 1'b1; F_nRE = 1'b1; F_nWP = 1'b1;
      dio_en = 1'b0; dio_drv = 8'h00; m_fail = 1'b0;
      test_reset;
      test_fill;
      test_program_read;
      test_col_wrap;
      test_status_busy;
      test_write_protect;
      test_read_id;
      test_reset_cmd;
      test_prst_busy;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/nand_flash_responder.md
# nand_flash_responder

Synthesizable NAND flash target that sits on the far end of the flash bus driven by the `fsm` controller (F_nCE/F_CLE/F_ALE/F_nWE/F_nRE/F_nWP out, F_nRB in, F_DIO bidirectional). It decodes command and address cycles, holds a small page array, and answers reads, programs, status, ID and reset with a realistic R/B busy window. It is the bench-side partner for controller verification and must behave identically in simulation and on FPGA.

## Interface
- PAGE_BYTES, 16: bytes per page; column wraps modulo this value (power of 2).
- NUM_PAGES, 8: pages in array; page index is taken modulo this value (power of 2).
- T_BUSY, 20: P_clk cycles F_nRB stays low after 30h or 10h.
- T_RST, 4: P_clk cycles F_nRB stays low after FFh.
- ID0, 8'hEC / ID1, 8'hD3: bytes returned by Read ID.

Ports:
- P_clk  in  1  system clock; all bus inputs sampled on rising edge.
- P_rst  in  1  synchronous, active-high reset.
- F_nCE  in  1  chip enable, active low; when high all strobes are ignored and F_DIO is released.
- F_CLE  in  1  command latch enable.
- F_ALE  in  1  address latch enable.
- F_nWE  in  1  write strobe; latch on rising edge.
- F_nRE  in  1  read strobe; data driven while low.
- F_nWP  in  1  write protect, active low.
- F_nRB  out  1  ready/busy, low = busy.
- F_DIO  inout  8  command/address/data bus.

## Operation
- Edge detect: register nWE_q, nRE_q, dio_q each cycle. A write strobe is a cycle with nWE_q=0, F_nWE=1, F_nCE=0; the latched byte is dio_q. A read-advance is nRE_q=0, F_nRE=1, F_nCE=0.
- Strobe classification by CLE/ALE (sampled with dio_q): CLE=1,ALE=0 command; CLE=0,ALE=1 address; both 0 data-in; both 1 ignored.
- Sequencer states: IDLE, ADDR, CONF. Output mode register: NONE, PAGE, STATUS, ID.
- 00h (not busy): ADDR, op=READ, addr_cnt=0, mode NONE. 80h: same, op=PROG. 90h: ADDR, op=ID, one address cycle expected.
- ADDR: address bytes stored by addr_cnt; byte0 = column (low bits), byte2 = page (low bits), bytes 1,3,4 accepted and discarded. After 5th (READ/PROG) go CONF; after 1st (ID) go IDLE, mode ID, id_idx=0.
- CONF/PROG: data-in strobes write page_reg[col], col++ with wrap.
- CONF/READ + 30h: copy array[page] to page_reg, busy_cnt=T_BUSY, mode PAGE after busy ends, state IDLE.
- CONF/PROG + 10h: if F_nWP=1 copy page_reg to array[page], fail=0; else array unchanged, fail=1. busy_cnt=T_BUSY, state IDLE, mode NONE.
- 70h (any state, including busy): mode STATUS; sequencer state unchanged.
- FFh (any state, including busy): state IDLE, mode NONE, col=0, fail=0, busy_cnt=T_RST (overrides running busy).
- Any other command, or a command not listed for the current state, or non-70h/FFh command while busy: ignored.
- Status byte: bit7=F_nWP, bit6=ready (busy_cnt==0), bit5=ready, bit0=fail, others 0.
- Read-advance: PAGE → col++ (wrap); ID → id_idx toggles 0↔1 (ID0, ID1, ID0, …); STATUS → no change.
- F_DIO driven when F_nCE=0, F_nRE=0, F_CLE=0, F_ALE=0, mode≠NONE, and (mode≠PAGE or not busy); value = page_reg[col] / status / ID byte; otherwise 8'hZZ.

## Timing
- Reset: state IDLE, mode NONE, col=0, addr_cnt=0, fail=0, busy_cnt=0, F_nRB=1, F_DIO=Z. Array and page_reg contents not reset. Reset mid-busy ends busy on the next cycle.
- Bus phases (nWE low/high, nRE low/high) each ≥1 P_clk cycle; DIO must be stable on the cycle before the nWE rise.
- Latch latency: command/address/data take effect at the clock edge where the nWE rise is detected (1 cycle after rise appears on pins).
- F_nRB falls on the clock edge after 30h/10h/FFh is latched; stays low exactly T_BUSY (or T_RST) cycles; F_nRB registered.
- F_DIO enable follows F_nRE combinationally; data reflects col/id_idx updated 1 cycle after nRE rise, so next nRE low must start ≥1 cycle after the rise.
- Simultaneous: FFh always wins; 70h during busy leaves busy_cnt running.

## Test plan
- Program/read: 80h, addr 03,00,02,00,00, data 11,22,33, 10h (F_nWP=1) → F_nRB low 20 cycles; then 00h, addr 03,00,02,00,00, 30h → after busy, three nRE pulses return 11,22,33.
- Column wrap: program 16 bytes starting at column 0Eh → data lands at columns 0E,0F,00..0D; readback from column 0 matches.
- Write protect: program page 5 with F_nWP=0 → 70h returns 8'h61; page 5 readback unchanged.
- Status during busy: 70h issued 3 cycles after 30h → status 8'h80 while busy, 8'hE0 after F_nRB rises without reissuing 70h.
- Read ID: 90h, addr 00 → four nRE pulses return EC,D3,EC,D3; F_DIO Z when F_nCE=1.
- Reset: FFh mid-address and mid-busy → F_nRB low exactly 4 cycles, state IDLE; P_rst during busy → F_nRB=1 next cycle, F_DIO Z.
